fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing the write port of one dcfifo instance among NUM_REQ requesters in the FIFO write clock domain.
- Grants whole bursts, terminated by req_last or BURST_MAX beats, so beats from different sources never interleave.
- Drives the FIFO data/wrreq from registers and throttles requesters on wrpfull/wrfull.
- Sits directly in front of the dcfifo write side. The read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 178 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter driving the write port of a shared dcfifo from registers.
// Optional mid-burst idle timeout is enabled by defining FIFO_WR_ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned BURST_MAX  = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                          wrclk,
  input  logic                          aclr_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic                          fifo_wrreq,
  input  logic                          fifo_wrfull,
  input  logic                          fifo_wrpfull,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          timeout_err
);

  localparam int unsigned GW   = $clog2(NUM_REQ);
  localparam int unsigned CntW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_MAX < 1 || BURST_MAX > 256 || TIMEOUT < 1)
  begin : g_bad_cfg
    $error("fifo_wr_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StBurst, StStall} state_e;

  state_e                state_q, state_d;
  logic [GW-1:0]         rr_q, rr_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wrreq_q, wrreq_d;
  logic                  terr_q, terr_d;

  logic                  can_accept;
  logic                  sel_valid, sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  accept, burst_end, timeout_hit;
  logic [GW-1:0]         pick, grant_next;
  logic                  pick_vld;
  int unsigned           idx;

  assign can_accept = (state_q == StBurst) & ~fifo_wrpfull & ~fifo_wrfull;

  always_comb begin
    req_ready = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == GW'(i)) begin
        req_ready[i] = can_accept;
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign accept     = sel_valid & can_accept;
  assign burst_end  = accept & (sel_last | (cnt_q == CntW'(BURST_MAX - 1)));
  assign grant_next = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Walk offsets high to low so the nearest valid requester above rr_q wins.
  always_comb begin
    pick     = rr_q;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(rr_q) + i) % NUM_REQ;
      if (req_valid[idx]) begin
        pick     = GW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

`ifdef FIFO_WR_ARB_TIMEOUT_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);

  logic [IdleW-1:0] idle_q, idle_d;

  // Counts consecutive granted-but-silent BURST cycles; STALL freezes it.
  always_comb begin
    idle_d = '0;
    if (state_q == StStall) begin
      idle_d = idle_q;
    end else if (state_q == StBurst && !sel_valid) begin
      idle_d = idle_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == StBurst) & ~sel_valid & (idle_q == IdleW'(TIMEOUT - 1));

  always_ff @(posedge wrclk or negedge aclr_n) begin
    if (!aclr_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    wrreq_d = accept;
    data_d  = accept ? sel_data : data_q;
    terr_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = StBurst;
        end
      end
      StBurst: begin
        if (burst_end) begin
          state_d = StIdle;
          rr_d    = grant_next;
          cnt_d   = '0;
        end else if (accept) begin
          cnt_d = cnt_q + 1'b1;
        end else if (fifo_wrpfull) begin
          state_d = StStall;
        end else if (timeout_hit) begin
          state_d = StIdle;
          rr_d    = grant_next;
          cnt_d   = '0;
          terr_d  = 1'b1;
        end
      end
      StStall: begin
        if (!fifo_wrpfull) state_d = StBurst;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wrclk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      wrreq_q <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      wrreq_q <= wrreq_d;
      terr_q  <= terr_d;
    end
  end

  assign fifo_data   = data_q;
  assign fifo_wrreq  = wrreq_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q != StIdle);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-requester beat queues drive the DUT and a burst-level
// round-robin model predicts the exact FIFO write stream.
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 12;
  localparam int BMAX = 8;
  localparam int TMO  = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  typedef struct packed {
    logic [3:0]    src;
    logic [DW-1:0] data;
  } exp_t;

  logic                 tb_wclk = 1'b0;
  logic                 aclr_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [DW-1:0]        fifo_data;
  logic                 fifo_wrreq;
  logic                 fifo_wrfull;
  logic                 fifo_wrpfull;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 timeout_err;

  fifo_wr_arbiter #(
    .NUM_REQ    (NREQ),
    .DATA_WIDTH (DW),
    .BURST_MAX  (BMAX),
    .TIMEOUT    (TMO)
  ) dut (
    .wrclk        (tb_wclk),
    .aclr_n       (aclr_n),
    .req_valid    (req_valid),
    .req_last     (req_last),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_data    (fifo_data),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_wrfull  (fifo_wrfull),
    .fifo_wrpfull (fifo_wrpfull),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 tb_wclk = ~tb_wclk;

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t rq [NREQ][$];
  exp_t  exp_q [$];
  logic  acc_prev = 1'b0;
  int    to_seen  = 0;
  int    exp_to   = 0;
  // Burst-level model state: next round-robin start and any burst left open.
  int    m_rr = 0;
  bit    m_open = 1'b0;
  int    m_src = 0;
  int    m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_burst(input int src, input int len, input int base);
    for (int k = 0; k < len; k++) begin
      rq[src].push_back('{data: DW'(base + k), last: (k == len - 1)});
    end
  endtask

  // Expands all queued beats into the write stream that round-robin burst arbitration implies.
  function automatic void gen_expected();
    beat_t cq [NREQ][$];
    beat_t b;
    int    sel;
    for (int i = 0; i < NREQ; i++) cq[i] = rq[i];
    while (1) begin
      if (!m_open) begin
        sel = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (sel < 0 && cq[(m_rr + k) % NREQ].size() > 0) sel = (m_rr + k) % NREQ;
        end
        if (sel < 0) break;
        m_open = 1'b1;
        m_src  = sel;
        m_cnt  = 0;
      end
      if (cq[m_src].size() == 0) begin
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        m_open = 1'b0;
        m_rr   = (m_src + 1) % NREQ;
        exp_to++;
        continue;
`else
        break;
`endif
      end
      b = cq[m_src].pop_front();
      exp_q.push_back('{src: 4'(m_src), data: b.data});
      m_cnt++;
      if (b.last || m_cnt == BMAX) begin
        m_open = 1'b0;
        m_rr   = (m_src + 1) % NREQ;
      end
    end
  endfunction

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = rq[i][0].last;
        req_data[i*DW +: DW]  = rq[i][0].data;
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge tb_wclk);
    aclr_n = 1'b0;
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
    acc_prev = 1'b0;
    m_rr = 0; m_open = 1'b0; m_src = 0; m_cnt = 0;
    for (int c = 0; c < n; c++) begin
      req_valid    = NREQ'($urandom);
      req_last     = NREQ'($urandom);
      fifo_wrpfull = 1'b0;
      fifo_wrfull  = 1'b0;
      #1;
      chk("rst_wrreq", fifo_wrreq, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_terr", timeout_err, 0);
      chk("rst_data", fifo_data, 0);
      @(negedge tb_wclk);
    end
    req_valid = '0;
    req_last  = '0;
    aclr_n    = 1'b1;
  endtask

  task automatic run(input int n, input int hold_after, input int hold_len, input bit rand_pf);
    int   acc_cnt = 0;
    int   hold_left = hold_len;
    bit   in_hold;
    logic pf;
    exp_t e;
    logic [NREQ-1:0] acc;
    for (int c = 0; c < n; c++) begin
      @(negedge tb_wclk);
      chk("wrreq_latency", fifo_wrreq, acc_prev);
      if (fifo_wrreq === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_beat", fifo_wrreq, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", fifo_data, e.data);
          chk("beat_grant", grant_id, e.src);
        end
      end
      if (timeout_err === 1'b1) to_seen++;
      in_hold = (hold_left > 0) && (acc_cnt >= hold_after);
      if (in_hold) begin
        pf = 1'b1;
        hold_left--;
      end else begin
        pf = rand_pf ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      fifo_wrpfull = pf;
      fifo_wrfull  = pf & 1'($urandom_range(0, 1));
      drive_reqs();
      #1;
      if (pf) chk("ready_throttled", req_ready, 0);
      if (in_hold) chk("stall_busy", busy, 1);
      chk("ready_onehot", ($countones(req_ready) <= 1), 1);
      acc      = req_valid & req_ready;
      acc_prev = |acc;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i]) begin
          void'(rq[i].pop_front());
          acc_cnt++;
        end
      end
    end
  endtask

  initial begin
    aclr_n       = 1'b0;
    req_valid    = '0;
    req_last     = '0;
    req_data     = '0;
    fifo_wrfull  = 1'b0;
    fifo_wrpfull = 1'b0;

    // Reset held 10 cycles, then idle
    do_reset(10);
    run(4, 0, 0, 1'b0);
    chk("idle_busy", busy, 0);

    // Single burst from requester 2
    push_burst(2, 5, 'h001);
    gen_expected();
    run(12, 0, 0, 1'b0);
    chk("single_drained", exp_q.size(), 0);
    chk("single_grant", grant_id, 2);
    chk("single_idle", busy, 0);

    // Round-robin, all requesters, 3-beat bursts
    do_reset(2);
    for (int i = 0; i < NREQ; i++) begin
      push_burst(i, 3, 'h100 * i);
      push_burst(i, 3, 'h100 * i + 'h80);
    end
    gen_expected();
    run(50, 0, 0, 1'b0);
    chk("rr_drained", exp_q.size(), 0);

    // Burst cap: requester 1 sends 20 beats, requester 3 competes
    do_reset(2);
    push_burst(1, 20, 'h100);
    for (int k = 0; k < 3; k++) push_burst(3, 2, 'h300 + 'h10 * k);
    gen_expected();
    run(60, 0, 0, 1'b0);
    chk("cap_drained", exp_q.size(), 0);

    // Backpressure after beat 3 for 10 cycles; cap still at 8 afterwards
    do_reset(2);
    push_burst(0, 10, 'h500);
    push_burst(1, 2, 'h600);
    gen_expected();
    run(60, 3, 10, 1'b0);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_idle", busy, 0);

    // Randomized traffic with random almost-full throttling
    for (int r = 0; r < 6; r++) begin
      int total = 0;
      for (int i = 0; i < NREQ; i++) begin
        int nb = $urandom_range(0, 3);
        for (int b = 0; b < nb; b++) begin
          int len = $urandom_range(1, 12);
          push_burst(i, len, $urandom_range(0, 4095));
          total += len;
        end
      end
      gen_expected();
      run(total * 4 + 60, 0, 0, 1'b1);
      chk("rand_drained", exp_q.size(), 0);
      chk("rand_idle", busy, 0);
    end

    // Reset mid-burst abandons it
    do_reset(2);
    push_burst(0, 6, 'h700);
    gen_expected();
    run(4, 0, 0, 1'b0);
    do_reset(2);
    run(6, 0, 0, 1'b0);
    chk("abandon_idle", busy, 0);

    // Requester 0 goes silent mid-burst while requester 1 waits
    do_reset(2);
    to_seen = 0;
    exp_to  = 0;
    rq[0].push_back('{data: DW'('h0a1), last: 1'b0});
    rq[0].push_back('{data: DW'('h0a2), last: 1'b0});
    push_burst(1, 3, 'h1b0);
    gen_expected();
    run(120, 0, 0, 1'b0);
    chk("silent_drained", exp_q.size(), 0);
    chk("timeout_pulses", to_seen, exp_to);
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    chk("timeout_released", busy, 0);
`else
    chk("held_grant", grant_id, 0);
    chk("held_busy", busy, 1);
`endif
    rq[0].push_back('{data: DW'('h0a3), last: 1'b1});
    gen_expected();
    run(30, 0, 0, 1'b0);
    chk("resume_drained", exp_q.size(), 0);
    chk("resume_idle", busy, 0);

    req_valid = '0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
